// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: function codes, ALU select
// codes, response error codes and the controller state encoding.
package alu_pkg;

  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_SUB  = 4'd1;
  localparam logic [3:0] SEL_AND  = 4'd2;
  localparam logic [3:0] SEL_OR   = 4'd3;
  localparam logic [3:0] SEL_SLT  = 4'd4;
  localparam logic [3:0] SEL_PASS = 4'd5;
  localparam logic [3:0] SEL_MUL  = 4'd6;
  localparam logic [3:0] SEL_DIV  = 4'd7;
  localparam logic [3:0] SEL_EQ   = 4'd8;
  localparam logic [3:0] SEL_ZTST = 4'd9;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_PASS = 6'h00;
  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_EQ   = 6'h30;
  localparam logic [5:0] FN_ZTST = 6'h31;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_DIV0 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational translation of a 6-bit function code into the ALU select
// code, flagging codes the ALU does not implement.
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output logic       legal,
  output logic [3:0] sel
);

  always_comb begin
    legal = 1'b1;
    sel   = SEL_ADD;
    case (funct)
      FN_ADD:  sel = SEL_ADD;
      FN_SUB:  sel = SEL_SUB;
      FN_AND:  sel = SEL_AND;
      FN_OR:   sel = SEL_OR;
      FN_SLT:  sel = SEL_SLT;
      FN_PASS: sel = SEL_PASS;
      FN_MUL:  sel = SEL_MUL;
      FN_DIV:  sel = SEL_DIV;
      FN_EQ:   sel = SEL_EQ;
      FN_ZTST: sel = SEL_ZTST;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator for a combinational ALU: accepts an op, drives the ALU for
// ALU_LAT cycles, captures the result and returns it over a response handshake.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int W       = 32,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [5:0]   op_funct,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic [W-1:0] alu_ea,
  output logic [W-1:0] alu_eb,
  output logic [3:0]   alu_sel,
  input  logic [W-1:0] alu_res,
  input  logic         alu_flag,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_zero,
  output logic [1:0]   res_err,
  output logic         busy
);

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       dec_legal;
  logic [3:0] dec_sel;
  logic       accept;
  logic       div_zero;
  logic       issue;
  logic       trap;
  logic       capture;

  alu_funct_decode u_decode (
    .funct (op_funct),
    .legal (dec_legal),
    .sel   (dec_sel)
  );

  // Traps skip the ALU entirely and go straight to the response stage.
  assign accept   = op_valid && op_ready;
  assign div_zero = (op_funct == FN_DIV) && (op_b == '0);
  assign issue    = accept && dec_legal && !div_zero;
  assign trap     = accept && !(dec_legal && !div_zero);
  assign capture  = (state == ST_WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (issue)     state_next = ST_WAIT;
        else if (trap) state_next = ST_HOLD;
      end
      ST_WAIT: if (cnt == 4'd0) state_next = ST_HOLD;
      ST_HOLD: if (res_ready)   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    res_valid = (state == ST_HOLD);
  end

  // ALU operand registers only move on a legal accept so the ALU sees stable inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ea  <= '0;
      alu_eb  <= '0;
      alu_sel <= 4'd0;
    end else if (issue) begin
      alu_ea  <= op_a;
      alu_eb  <= op_b;
      alu_sel <= dec_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                cnt <= 4'd0;
    else if (issue)                         cnt <= LAT_LOAD;
    else if (state == ST_WAIT && cnt != 0)  cnt <= cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= '0;
      res_zero <= 1'b0;
      res_err  <= ERR_OK;
    end else if (trap) begin
      res_data <= '0;
      res_zero <= 1'b1;
      res_err  <= dec_legal ? ERR_DIV0 : ERR_ILL;
    end else if (capture) begin
      res_data <= alu_res;
      res_zero <= alu_flag;
      res_err  <= ERR_OK;
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the combinational ALU interface (operands EA/EB, 4-bit select, result, zero flag).
- Accepts decoded operations from the datapath control over a valid/ready handshake.
- Translates the 6-bit function code to the ALU select code, drives the ALU operands, and waits a programmable latency.
- Captures the ALU result and flag, then returns them over a second valid/ready handshake.
- Traps illegal codes and divide-by-zero without issuing to the ALU.

Parameters:
- W, 32, operand/result width; must match ALU width.
- ALU_LAT, 1, cycles from ALU inputs stable to capture; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- op_valid  in  1  request valid.
- op_ready  out  1  request accepted when op_valid && op_ready.
- op_funct  in  6  function code.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- alu_ea  out  W  to ALU EA.
- alu_eb  out  W  to ALU EB.
- alu_sel  out  4  to ALU sel.
- alu_res  in  W  from ALU res.
- alu_flag  in  1  from ALU flag (1 when res==0).
- res_valid  out  1  response valid.
- res_ready  in  1  response consumed when res_valid && res_ready.
- res_data  out  W  captured result.
- res_zero  out  1  captured flag.
- res_err  out  2  00 ok, 01 illegal funct, 10 divide-by-zero.
- busy  out  1  high in any state but IDLE.

Behaviour:
- Reset values:
  - op_ready=1, res_valid=0, res_data=0, res_zero=0, res_err=00, busy=0.
  - alu_ea=0, alu_eb=0, alu_sel=4'd0.
  - Reset has priority over all events. Reset mid-operation discards the in-flight op; no response is produced.
- Decode table (funct -> sel):
  - 0x20 add -> 0; 0x22 sub -> 1; 0x24 and -> 2; 0x25 or -> 3.
  - 0x2A slt -> 4 (unsigned compare); 0x00 pass A -> 5.
  - 0x18 mul -> 6; 0x1A div -> 7.
  - 0x30 eq-test -> 8; 0x31 zero-test -> 9.
  - Any other code is illegal.
- States: IDLE, WAIT, HOLD.
- IDLE:
  - op_ready=1.
  - On handshake with a legal funct, and not (funct==0x1A && op_b==0):
    - register op_a/op_b into alu_ea/alu_eb and the decoded sel into alu_sel;
    - load the wait counter with ALU_LAT-1;
    - go to WAIT.
  - On handshake with an illegal funct:
    - res_data=0, res_zero=1, res_err=01, res_valid=1;
    - go to HOLD;
    - ALU registers are unchanged.
  - On handshake with divide by zero:
    - res_data=0, res_zero=1, res_err=10, res_valid=1;
    - go to HOLD.
- WAIT:
  - op_ready=0.
  - The counter decrements each cycle.
  - In the cycle the counter is 0: capture alu_res into res_data and alu_flag into res_zero, set res_err=00 and res_valid=1, then go to HOLD.
  - Latency from accept to res_valid is ALU_LAT+1 cycles; it is 2 for ALU_LAT=1.
- HOLD:
  - op_ready=0.
  - res_* are held stable until res_ready.
  - On res_ready: res_valid=0 next cycle, go to IDLE.
  - No back-to-back accept in the release cycle. Issue rate is at most one op per ALU_LAT+2 cycles, or one per 2 cycles on the error path.
- alu_ea/alu_eb/alu_sel hold their last value in all states; they change only on a legal accept.
- res_ready asserted while res_valid=0 is ignored.
- op_* inputs are sampled only at handshake.
- No arithmetic in this block; the comparison op_b==0 is on full W bits.

Decomposition:
- Shared package alu_pkg holds:
  - the localparams for the ten select codes (SEL_ADD..SEL_ZTST) and the ten funct codes;
  - the error codes ERR_OK/ERR_ILL/ERR_DIV0;
  - the state encoding.
- One sub-module, alu_funct_decode: combinational funct -> {legal, sel[3:0]}, reusable by the main control unit.
- The bench instantiates the real ALU as the responder.

Test Plan:
- add: funct=0x20, a=5, b=7, ALU_LAT=1 -> res_valid 2 cycles after accept, res_data=12, res_zero=0, res_err=00.
- sub to zero with response stalled: funct=0x22, a=b=0x1234, res_ready held low 5 cycles -> res_data=0, res_zero=1, outputs stable throughout, op_ready=0 until the release cycle+1.
- div by zero: funct=0x1A, a=9, b=0 -> res_err=10 one cycle after accept; alu_sel/alu_ea/alu_eb unchanged from the previous op.
- illegal code: funct=0x3F -> res_err=01, res_data=0; the next legal op (0x2A, a=3, b=4) returns res_data=1.
- latency param: ALU_LAT=4 with funct=0x18, a=6, b=7 -> res_data=42 exactly 5 cycles after accept; busy high for the whole interval.
- reset mid-op: rst asserted in WAIT -> next cycle all outputs at reset values, no res_valid, a fresh op completes normally.
